// File: rtl/data_sram_axi_bridge_pkg.sv
// Shared types and AXI constants for the data-side SRAM-to-AXI bridge.
package data_sram_axi_bridge_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_AR  = 3'd1,
        S_RD_R   = 3'd2,
        S_WR_AWW = 3'd3,
        S_WR_B   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

    // True when a response code reports anything other than OKAY.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/data_sram_axi_bridge_if.sv
// AXI4 single-beat channel bundle between the bridge (master) and the interconnect (slave).
interface data_sram_axi_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [3:0]          arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    logic [3:0]          awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/data_sram_axi_bridge.sv
// Converts each blocking single-word data_sram request into one AXI4 single-beat
// transaction, stalling the pipeline until the transaction has completed.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no access pending; accepts a new request when en=1
// RD_AR    | read address offered, waiting for arready
// RD_R     | waiting for the read beat; rdata captured on rvalid
// WR_AWW   | write address and data offered; each drops on its own handshake
// WR_B     | waiting for the write response
// DONE     | one cycle with stall released; the held request is ignored here
module data_sram_axi_bridge
    import data_sram_axi_bridge_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd1,
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_sram_en,
    input  logic [DATA_W/8-1:0]   data_sram_wen,
    input  logic [ADDR_W-1:0]     data_sram_addr,
    input  logic [DATA_W-1:0]     data_sram_wdata,
    output logic [DATA_W-1:0]     data_sram_rdata,
    output logic                  stallreq,
    output logic                  bus_err,
    data_sram_axi_bridge_if.master axi
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W/8-1:0]   r_wstrb;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_bus_err;

    logic                  w_awvalid;
    logic                  w_wvalid;
    logic                  w_aw_fire;
    logic                  w_w_fire;
    logic                  w_r_fire;
    logic                  w_b_fire;

    assign w_awvalid = (r_state == S_WR_AWW) && !r_aw_done;
    assign w_wvalid  = (r_state == S_WR_AWW) && !r_w_done;
    assign w_aw_fire = w_awvalid && axi.awready;
    assign w_w_fire  = w_wvalid && axi.wready;
    assign w_r_fire  = (r_state == S_RD_R) && axi.rvalid;
    assign w_b_fire  = (r_state == S_WR_B) && axi.bvalid;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (data_sram_en)
                          w_state_nxt = (data_sram_wen == '0) ? S_RD_AR : S_WR_AWW;
            S_RD_AR:  if (axi.arready) w_state_nxt = S_RD_R;
            S_RD_R:   if (axi.rvalid)  w_state_nxt = S_DONE;
            S_WR_AWW: if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire))
                          w_state_nxt = S_WR_B;
            S_WR_B:   if (axi.bvalid)  w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Request latch: fields stay frozen for the whole transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else if (r_state == S_IDLE && data_sram_en) begin
            r_addr  <= {data_sram_addr[ADDR_W-1:2], 2'b00};
            r_wdata <= data_sram_wdata;
            r_wstrb <= data_sram_wen;
        end
    end

    // Per-channel done flags so AW and W can complete in either order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (r_state != S_WR_AWW) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_aw_fire) r_aw_done <= 1'b1;
            if (w_w_fire)  r_w_done  <= 1'b1;
        end
    end

    // Read data capture and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata   <= '0;
            r_bus_err <= 1'b0;
        end else begin
            if (w_r_fire) r_rdata <= axi.rdata;
            if ((w_r_fire && resp_is_err(axi.rresp)) || (w_b_fire && resp_is_err(axi.bresp)))
                r_bus_err <= 1'b1;
        end
    end

    assign stallreq = ((r_state == S_IDLE) && data_sram_en) ||
                      ((r_state != S_IDLE) && (r_state != S_DONE));
    assign data_sram_rdata = r_rdata;
    assign bus_err         = r_bus_err;

    assign axi.arid    = AXI_ID;
    assign axi.araddr  = r_addr;
    assign axi.arlen   = AXI_LEN_SINGLE;
    assign axi.arsize  = AXI_SIZE_4B;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arvalid = (r_state == S_RD_AR);
    assign axi.rready  = (r_state == S_RD_R);

    assign axi.awid    = AXI_ID;
    assign axi.awaddr  = r_addr;
    assign axi.awlen   = AXI_LEN_SINGLE;
    assign axi.awsize  = AXI_SIZE_4B;
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.awvalid = w_awvalid;
    assign axi.wdata   = r_wdata;
    assign axi.wstrb   = r_wstrb;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = w_wvalid;
    assign axi.bready  = (r_state == S_WR_B);

endmodule
